// File: rtl/sum_series_inverse.sv
// Inverse series engine: finds the largest N with 1+2+...+N <= S and the leftover.
// One trial addition per clock; Start/Busy/Done handshake like the forward engine.
module sum_series_inverse #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [W-1:0] Data_in,
    output logic [W-1:0] Root,
    output logic [W-1:0] Rem,
    output logic         Busy,
    output logic         Done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [W-1:0] s_r;
    logic [W-1:0] count;
    logic [W:0]   acc;
    logic [W:0]   trial;
    logic         load;
    logic         step;
    logic         finish;
    logic         clear;

    // Trial sum carries one extra bit so S near 2^W never wraps.
    assign trial = acc + {1'b0, count} + (W+1)'(1);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        clear      = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (trial <= {1'b0, s_r}) begin
                    step = 1'b1;
                end else begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (Start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            default: begin
                clear      = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s_r   <= '0;
            count <= '0;
            acc   <= '0;
            Root  <= '0;
            Rem   <= '0;
        end else if (clear) begin
            s_r   <= '0;
            count <= '0;
            acc   <= '0;
            Root  <= '0;
            Rem   <= '0;
        end else begin
            if (load) begin
                s_r   <= Data_in;
                count <= '0;
                acc   <= '0;
            end
            if (step) begin
                acc   <= trial;
                count <= count + 1'b1;
            end
            // Results move only on the RUN->DONE edge, so no partial value is ever visible.
            if (finish) begin
                Root <= count;
                Rem  <= s_r - acc[W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_sum_series_inverse.sv
// Bench for sum_series_inverse: timeline reference model checked every cycle,
// directed literal cases, exhaustive sweep and randomized Start traffic.
module tb_sum_series_inverse;

    localparam int W = 8;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [W-1:0] Data_in;
    logic [W-1:0] Root;
    logic [W-1:0] Rem;
    logic         Busy;
    logic         Done;

    int checks = 0;
    int errors = 0;

    sum_series_inverse #(.W(W)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .Data_in(Data_in),
        .Root   (Root),
        .Rem    (Rem),
        .Busy   (Busy),
        .Done   (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Largest n with n(n+1)/2 <= s, found by plain search over triangular numbers.
    function automatic void ref_calc(input int s, output int r, output int m);
        int n;
        n = 0;
        while ((n + 1) * (n + 2) / 2 <= s) n++;
        r = n;
        m = s - n * (n + 1) / 2;
    endfunction

    // Timeline model: 0 idle, 1 running, 2 done. A run lasts root+1 edges after accept.
    int m_phase, m_left, m_root, m_rem, p_root, p_rem;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_phase = 0;
            m_left  = 0;
            m_root  = 0;
            m_rem   = 0;
        end else begin
            case (m_phase)
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_root  = p_root;
                        m_rem   = p_rem;
                    end
                end
                default: begin
                    if (Start) begin
                        ref_calc(int'(Data_in), p_root, p_rem);
                        m_left  = p_root + 1;
                        m_phase = 1;
                    end
                end
            endcase
        end
    end

    always @(negedge Clk) begin
        check("busy", int'(Busy), int'(m_phase == 1));
        check("done", int'(Done), int'(m_phase == 2));
        check("root", int'(Root), m_root);
        check("rem",  int'(Rem),  m_rem);
    end

    // Accept S, then count edges until Done; expects Done after exp_r+1 edges past accept.
    task automatic run_one(input int s, input int exp_r, input int exp_m);
        int cycles;
        @(negedge Clk);
        Data_in = W'(s);
        Start   = 1'b1;
        @(negedge Clk);
        Start   = 1'b0;
        cycles  = 0;
        while (!Done && cycles < 100) begin
            @(negedge Clk);
            cycles++;
        end
        check("latency", cycles + 1, exp_r + 2);
        check("run_root", int'(Root), exp_r);
        check("run_rem",  int'(Rem),  exp_m);
    endtask

    initial begin
        int r, m;
        Reset   = 1'b1;
        Start   = 1'b0;
        Data_in = '0;
        repeat (2) @(negedge Clk);
        check("rst_root", int'(Root), 0);
        check("rst_rem",  int'(Rem),  0);
        check("rst_busy", int'(Busy), 0);
        check("rst_done", int'(Done), 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        run_one(10, 4, 0);
        repeat (4) @(negedge Clk);
        check("hold_done", int'(Done), 1);
        check("hold_root", int'(Root), 4);
        run_one(0, 0, 0);
        run_one(1, 1, 0);
        run_one(14, 4, 4);
        run_one(255, 22, 2);

        // Start during RUN is ignored.
        @(negedge Clk);
        Data_in = 8'd15;
        Start   = 1'b1;
        @(negedge Clk);
        Start   = 1'b0;
        repeat (2) @(negedge Clk);
        Data_in = 8'd3;
        Start   = 1'b1;
        @(negedge Clk);
        Start   = 1'b0;
        repeat (10) @(negedge Clk);
        check("ign_done", int'(Done), 1);
        check("ign_root", int'(Root), 5);
        check("ign_rem",  int'(Rem),  0);
        // Restart from DONE: old result holds until the new DONE edge.
        Data_in = 8'd3;
        Start   = 1'b1;
        @(negedge Clk);
        Start   = 1'b0;
        check("rs_done", int'(Done), 0);
        check("rs_root", int'(Root), 5);
        repeat (2) @(negedge Clk);
        check("rs_hold_rem", int'(Rem), 0);
        check("rs_hold_root", int'(Root), 5);
        @(negedge Clk);
        check("rs2_done", int'(Done), 1);
        check("rs2_root", int'(Root), 2);
        check("rs2_rem",  int'(Rem),  0);

        // Asynchronous reset mid-RUN.
        Data_in = 8'd200;
        Start   = 1'b1;
        @(negedge Clk);
        Start   = 1'b0;
        repeat (5) @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("ar_busy", int'(Busy), 0);
        check("ar_done", int'(Done), 0);
        check("ar_root", int'(Root), 0);
        check("ar_rem",  int'(Rem),  0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        check("ar_idle_busy", int'(Busy), 0);
        check("ar_idle_done", int'(Done), 0);

        for (int s = 0; s < 256; s++) begin
            ref_calc(s, r, m);
            run_one(s, r, m);
        end

        // Random traffic, with stretches of Start held high.
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            Data_in = W'($urandom_range(0, 255));
            if ((i / 300) % 3 == 2) Start = 1'b1;
            else Start = ($urandom_range(0, 5) == 0);
        end
        @(negedge Clk);
        Start = 1'b0;
        repeat (30) @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
